// File: rtl/seg_pkg.sv
// Shared types and constants for the serial seven-segment driver.
// Combinational content only; no latency, no flow control.
// Provides the FSM state enum, the hex-to-segment table, the blank byte and the frame size.
package seg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } seg_state_t;

  localparam int FRAME_BITS = 64;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; element 0 is hex digit 0. Bit 7 is replaced by the dot flag.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_seg.sv
// Decodes one hex nibble plus its decimal point into an active-low segment byte.
// Purely combinational, zero latency.
// No flow control; the output follows the inputs.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dot,
  input  logic       blank,
  output logic [7:0] seg
);

  // The decimal point stays independent of blanking so a blanked digit can still show its dp.
  assign seg = {~dot, blank ? SEG_BLANK[6:0] : HEX_SEG[nib][6:0]};

endmodule

// File: rtl/seg_serial_driver.sv
// Continuously shifts a 64-bit seven-segment frame (8 hex digits) out on SEGCLK/SEGDT.
// Frame period GAP_CYCLES + 1 + 128*CLK_DIV + 1 clk cycles; dat/dot are sampled once per frame in LOAD.
// No backpressure: free-running; SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dat,
  input  logic [7:0]  dot,
  output logic        SEGCLK,
  output logic        SEGDT,
  output logic        SEGCLR,
  output logic        SEGEN,
  output logic        busy,
  output logic        done
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [5:0]    BIT_LAST  = 6'(FRAME_BITS - 1);

  seg_state_t        state;
  logic [5:0]        bitcnt;
  logic [HW-1:0]     half_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [63:0]       shreg;
  logic [7:0][7:0]   seg_byte;
  logic [63:0]       frame;
  logic [7:0]        blank;

  for (genvar i = 0; i < 8; i++) begin : g_digit
`ifdef SEG_BLANK_LEADING_ZERO_EN
    // A digit blanks only when it and every digit to its left are zero; digit 0 always shows.
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = ((dat >> (4 * i)) == 32'd0);
    end
`else
    assign blank[i] = 1'b0;
`endif

    hex_to_seg u_hex_to_seg (
      .nib   (dat[4*i +: 4]),
      .dot   (dot[i]),
      .blank (blank[i]),
      .seg   (seg_byte[i])
    );
  end

  assign frame = seg_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitcnt   <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      SEGCLK   <= 1'b0;
      SEGDT    <= 1'b0;
      SEGCLR   <= 1'b0;
      SEGEN    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      SEGCLR <= 1'b1;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            busy    <= 1'b1;
            state   <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        LOAD: begin
          shreg    <= frame;
          SEGDT    <= frame[63];
          SEGCLK   <= 1'b0;
          bitcnt   <= '0;
          half_cnt <= '0;
          state    <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            SEGCLK   <= 1'b1;
            state    <= SHIFT_HI;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            SEGCLK   <= 1'b0;
            if (bitcnt == BIT_LAST) begin
              done  <= 1'b1;
              SEGEN <= 1'b1;
              state <= DONE;
            end else begin
              // Data moves on the falling edge so it is settled well before the next rise.
              shreg  <= shreg << 1;
              SEGDT  <= shreg[62];
              bitcnt <= bitcnt + 1'b1;
              state  <= SHIFT_LO;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: captures SEGDT on SEGCLK rises and compares whole frames.
module tb_seg_serial_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dat = 32'h1234_ABCD;
  logic [7:0]  dot = 8'h00;
  logic        SEGCLK, SEGDT, SEGCLR, SEGEN, busy, done;

  int checks = 0;
  int errors = 0;
  logic prev_clk;

  seg_serial_driver #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dat    (dat),
    .dot    (dot),
    .SEGCLK (SEGCLK),
    .SEGDT  (SEGDT),
    .SEGCLR (SEGCLR),
    .SEGEN  (SEGEN),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Samples on falling edges until done, an abort rise count, or the cycle budget runs out.
  task automatic capture(input int chg_at, input logic [31:0] chg_dat, input int abort_at,
                         output logic [63:0] bits, output int rises, output int cyc,
                         output bit segen_early, output bit timeout);
    bits = '0; rises = 0; cyc = 0; segen_early = 0; timeout = 1;
    prev_clk = SEGCLK;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (SEGCLK && !prev_clk) begin
        bits = {bits[62:0], SEGDT};
        rises++;
        if (rises == chg_at) dat = chg_dat;
        if (rises == abort_at) begin
          timeout = 0;
          break;
        end
      end
      prev_clk = SEGCLK;
      if (SEGEN && !done) segen_early = 1;
      if (done) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first_rise, done_cyc, busy_cyc;
    bit clr_ok;
    first_rise = -1; done_cyc = -1; busy_cyc = -1; clr_ok = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({SEGCLK, SEGDT, SEGCLR, SEGEN, busy, done} !== 6'b0)
      $display("FAIL reset_outputs got %b want 000000", {SEGCLK, SEGDT, SEGCLR, SEGEN, busy, done});
    rst_n = 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      if (c == 1) clr_ok = (SEGCLR === 1'b1);
      if (busy_cyc < 0 && busy === 1'b1) busy_cyc = c;
      if (first_rise < 0 && SEGCLK === 1'b1) first_rise = c;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    checks++;
    if (!clr_ok) begin errors++; $display("FAIL segclr_after_release got 0 want 1"); end
    checks++;
    if (busy_cyc !== 4) begin errors++; $display("FAIL busy_rise_cycle got %0d want 4", busy_cyc); end
    checks++;
    if (first_rise !== 7) begin errors++; $display("FAIL first_segclk_rise got %0d want 7", first_rise); end
    checks++;
    if (done_cyc !== 261) begin errors++; $display("FAIL first_done_cycle got %0d want 261", done_cyc); end
    checks++;
    if (SEGEN !== 1'b1) begin errors++; $display("FAIL segen_with_done got %b want 1", SEGEN); end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL busy_done_after_done got %b want 00", {busy, done}); end
  endtask

  task automatic test_decode();
    logic [63:0] bits; int rises, cyc; bit early, to;
    dat = 32'h1234_ABCD; dot = 8'h00;
    capture(-1, 32'h0, -1, bits, rises, cyc, early, to);
    checks++;
    if (to) begin errors++; $display("FAIL decode_timeout got no done want done"); end
    checks++;
    if (bits !== 64'hF9A4_B099_8883_C6A1) begin errors++; $display("FAIL decode_frame got %h want f9a4b0998883c6a1", bits); end
    checks++;
    if (rises !== 64) begin errors++; $display("FAIL decode_rises got %0d want 64", rises); end
  endtask

  task automatic test_dot();
    logic [63:0] bits, exp; int rises, cyc; bit early, to;
    dat = 32'h0; dot = 8'h01;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    exp = 64'hFFFF_FFFF_FFFF_FF40;
`else
    exp = 64'hC0C0_C0C0_C0C0_C040;
`endif
    capture(-1, 32'h0, -1, bits, rises, cyc, early, to);
    checks++;
    if (to || bits !== exp) begin errors++; $display("FAIL dot_frame got %h want %h", bits, exp); end
    checks++;
    if (SEGEN !== 1'b1) begin errors++; $display("FAIL dot_segen got %b want 1", SEGEN); end
  endtask

  task automatic test_leading_zero();
    logic [63:0] bits, exp; int rises, cyc; bit early, to;
    dat = 32'h0000_0050; dot = 8'h00;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    exp = 64'hFFFF_FFFF_FFFF_92C0;
`else
    exp = 64'hC0C0_C0C0_C0C0_92C0;
`endif
    capture(-1, 32'h0, -1, bits, rises, cyc, early, to);
    checks++;
    if (to || bits !== exp) begin errors++; $display("FAIL leading_zero_frame got %h want %h", bits, exp); end
  endtask

  task automatic test_mid_frame();
    logic [63:0] bits; int rises, cyc; bit early, to;
    dat = 32'h1111_1111;
    capture(20, 32'h2222_2222, -1, bits, rises, cyc, early, to);
    checks++;
    if (to || bits !== {8{8'hF9}}) begin errors++; $display("FAIL mid_frame_current got %h want f9f9f9f9f9f9f9f9", bits); end
    checks++;
    if (cyc !== 262) begin errors++; $display("FAIL mid_frame_period1 got %0d want 262", cyc); end
    capture(-1, 32'h0, -1, bits, rises, cyc, early, to);
    checks++;
    if (to || bits !== {8{8'hA4}}) begin errors++; $display("FAIL mid_frame_next got %h want a4a4a4a4a4a4a4a4", bits); end
    checks++;
    if (cyc !== 262) begin errors++; $display("FAIL mid_frame_period2 got %0d want 262", cyc); end
    checks++;
    if (rises !== 64) begin errors++; $display("FAIL mid_frame_rises got %0d want 64", rises); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits; int rises, cyc; bit early, to;
    dat = 32'h1234_ABCD;
    capture(-1, 32'h0, 30, bits, rises, cyc, early, to);
    checks++;
    if (to || rises !== 30) begin errors++; $display("FAIL mid_reset_reach_bit30 got %0d want 30", rises); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({SEGCLK, SEGDT, SEGCLR, SEGEN, busy, done} !== 6'b0)
      begin errors++; $display("FAIL mid_reset_outputs got %b want 000000", {SEGCLK, SEGDT, SEGCLR, SEGEN, busy, done}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(-1, 32'h0, -1, bits, rises, cyc, early, to);
    checks++;
    if (early) begin errors++; $display("FAIL mid_reset_segen_early got 1 want 0"); end
    checks++;
    if (to || cyc !== 261) begin errors++; $display("FAIL mid_reset_done_cycle got %0d want 261", cyc); end
    checks++;
    if (bits !== 64'hF9A4_B099_8883_C6A1 || rises !== 64)
      begin errors++; $display("FAIL mid_reset_frame got %h/%0d want f9a4b0998883c6a1/64", bits, rises); end
    checks++;
    if (SEGEN !== 1'b1) begin errors++; $display("FAIL mid_reset_segen_final got %b want 1", SEGEN); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_dot();
    test_leading_zero();
    test_mid_frame();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_serial_driver.md
# seg_serial_driver

Serial seven-segment display driver feeding the board's 8-digit shift-register display chain. It consumes a 32-bit display word from the CPU top level (register/PC/instruction value selected by the switches) and eight decimal-point flags. It refreshes the display continuously by decoding eight hex nibbles into active-low segment bytes and shifting the 64-bit frame out on SEGCLK/SEGDT. It also drives SEGCLR and SEGEN.

## Interface
- CLK_DIV, 2: clk cycles per SEGCLK half-period (≥1)
- GAP_CYCLES, 4: idle clk cycles between frames (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dat  in  32  display word; nibble i → digit i (digit 7 = dat[31:28], leftmost)
- dot  in  8  dot[i]=1 lights decimal point of digit i
- SEGCLK  out  1  serial shift clock; the shift register samples on the rising edge
- SEGDT  out  1  serial data, valid across each SEGCLK rising edge
- SEGCLR  out  1  active-low clear to the shift register
- SEGEN  out  1  display enable; sticky 1 after the first complete frame
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse per completed frame

## Operation
- Segment byte = {dp,g,f,e,d,c,b,a}, active-low.
  - Hex codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
  - Bit 7 = ~dot[i].
- Frame vector = {byte7, byte6, …, byte0}. Bit 63 is sent first, MSB-first within each byte.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
  - IDLE: counts GAP_CYCLES cycles → LOAD.
  - LOAD (1 cycle): latch dat/dot, build the frame, bitcnt=0. SEGDT=frame[63], SEGCLK=0. → SHIFT_LO.
  - SHIFT_LO: SEGCLK=0 for CLK_DIV cycles → SHIFT_HI.
  - SHIFT_HI: SEGCLK=1 for CLK_DIV cycles. On exit:
    - if bitcnt==63 → DONE;
    - otherwise shift left, update SEGDT to the next bit, bitcnt+1 → SHIFT_LO.
  - DONE (1 cycle): SEGCLK=0, done=1, SEGEN←1 → IDLE.
- SEGDT changes only while SEGCLK=0 (LOAD or the SHIFT_HI→SHIFT_LO transition). It never changes in the same cycle as a rising edge.
- dat/dot are sampled only in LOAD. Changes mid-frame appear in the next frame.
- Counters: bitcnt is 6 bits; the half-period counter is $clog2(CLK_DIV+1) bits; the gap counter is $clog2(GAP_CYCLES+1) bits. None of them wrap within a frame.

## Timing
- Reset values (asserted asynchronously, immediately):
  - SEGCLK=0, SEGDT=0, SEGCLR=0, SEGEN=0, busy=0, done=0;
  - state=IDLE, all counters 0.
- First clk edge after rst_n deassertion: SEGCLR←1. SEGCLR stays 1 until the next reset.
- Frame period = GAP_CYCLES + 1 + 128·CLK_DIV + 1 clk cycles. With the defaults this is 262.
- First LOAD occurs GAP_CYCLES cycles after reset release.
- Exactly 64 SEGCLK rising edges per frame. Each high phase lasts CLK_DIV cycles and each low phase lasts ≥ CLK_DIV cycles.
- Reset mid-frame: outputs return to reset values at once and the partial frame is discarded. SEGEN stays 0 until a full frame completes after the reset.
- done and SEGEN←1 occur in the same cycle. busy falls in the cycle after DONE.

## Configuration
- SEG_BLANK_LEADING_ZERO_EN defined: for digits 7..1, a digit whose nibble is 0 and whose higher nibbles are all 0 gets segment bits[6:0]=7F (blank). Its dp still follows ~dot[i]. Digit 0 is never blanked.
- SEG_BLANK_LEADING_ZERO_EN undefined: every digit is always decoded.

## Structure
- Package seg_pkg holds:
  - the FSM state enum;
  - the 16-entry hex→segment constant table;
  - SEG_BLANK (8'hFF) and FRAME_BITS (64).
- One sub-module: hex_to_seg. It is combinational, takes nibble + dot + blank and produces the 8-bit active-low byte. It is instantiated 8×.
- The leading-zero blank chain and the shift/FSM logic live in seg_serial_driver.

## Test plan
- Reset check: hold rst_n=0 → all outputs 0. After release, SEGCLR=1 after 1 cycle, first SEGCLK rise at cycle GAP_CYCLES+1+CLK_DIV, done at cycle 261 (defaults).
- Decode frame: dat=32'h1234_ABCD, dot=0 → bits captured on SEGCLK rises = F9 A4 B0 99 88 83 C6 A1. Exactly 64 rises, then SEGEN=1.
- Decimal point: dat=0, dot=8'h01 → last byte 40. Macro undefined → other bytes C0.
- Leading zeros: dat=32'h0000_0050.
  - Macro defined → FF FF FF FF FF FF 92 C0.
  - Macro undefined → C0 ×5, then 92 C0 (preceded by C0 for digit 2).
- Mid-frame update: change dat from 32'h1111_1111 to 32'h2222_2222 at bit 20 → current frame is all F9, next frame is all A4, done every 262 cycles.
- Reset mid-frame: assert rst_n=0 at bit 30 → immediate reset values, SEGEN=0 until the following full frame's done.
